// File: rtl/c_chunk_serializer.sv
// c_chunk_serializer: splits a word into chunk_width beats over valid/ready, natural or fully bit-reversed order.
// Optional out_parity port when C_CHUNK_SERIALIZER_PARITY_EN is defined.
module c_chunk_serializer #(
    parameter int width = 32,
    parameter int chunk_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:width-1]       in_data,
    input  logic                   in_lsb_first,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:chunk_width-1] out_data,
    output logic                   out_last,
    output logic                   busy
`ifdef C_CHUNK_SERIALIZER_PARITY_EN
    ,output logic                  out_parity
`endif
);
    localparam int num_chunks = width / chunk_width;
    localparam int cnt_w = num_chunks > 1 ? $clog2(num_chunks) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic [0:width-1]  data_q, data_d;
    logic [0:width-1]  rev;
    logic              beat, accept, at_last;

    // Reversed order is just natural chunking of the bit-reversed word.
    for (genvar i = 0; i < width; i++) begin : g_rev
        assign rev[i] = in_data[width-1-i];
    end

    assign out_valid = state_q == SHIFT;
    assign busy      = out_valid;
    assign at_last   = cnt_q == last_cnt;
    assign out_last  = out_valid & at_last;
    assign beat      = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (beat & at_last);
    assign accept    = in_valid & in_ready;
    assign out_data  = data_q[0:chunk_width-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            data_d  = in_lsb_first ? rev : in_data;
        end else if (beat) begin
            state_d = at_last ? IDLE : SHIFT;
            cnt_d   = at_last ? '0 : cnt_q + 1'b1;
            data_d  = at_last ? '0 : data_q << chunk_width;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

`ifdef C_CHUNK_SERIALIZER_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk) begin
        if (reset)
            parity_q <= 1'b0;
        else if (accept)
            parity_q <= ^in_data;
        else if (beat && at_last)
            parity_q <= 1'b0;
    end
    assign out_parity = parity_q;
`endif
endmodule

// File: doc/c_chunk_serializer.md
Name: c_chunk_serializer

Overview:
- Parallel-to-serial stage that takes a full-width word (from a bit-reversal stage or straight from the datapath) and emits it as a sequence of narrow chunks over a valid/ready link.
- Per-word order select: either natural chunk order, or full bit-reversed order. Bit-reversed order equals serializing the bit-reversed word, so no upstream reversal stage is needed.
- Used on narrow inter-router or off-chip channels. Throughput is one chunk per cycle with no inter-word bubbles.

Parameters:
- width, 32, input word width in bits; must be an integer multiple of chunk_width.
- chunk_width, 8, output chunk width in bits; 1 <= chunk_width <= width.
- num_chunks (derived localparam), width/chunk_width, beats per word; counter width clog2(num_chunks), minimum 1 bit.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_lsb_first are valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  [0:width-1]  parallel word; bit 0 is the most significant bit.
- in_lsb_first  input  1  sampled with the word. 0 = natural order, 1 = full bit reversal.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  downstream consumes the chunk this cycle.
- out_data  output  [0:chunk_width-1]  current chunk.
- out_last  output  1  current chunk is the final beat of the word.
- busy  output  1  a word is held (mirrors out_valid).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- State machine has two states:
  - IDLE: no word held.
  - SHIFT: word held, counter cnt in 0..num_chunks-1.
- Reset (synchronous, active-high) forces IDLE and clears cnt and the data register.
  - Outputs after reset: out_valid=0, out_last=0, busy=0, out_data=0, in_ready=1.
- in_ready is combinational: in_ready = IDLE | (out_valid & out_ready & out_last).
- Accept occurs when in_valid & in_ready.
  - Captures in_data and in_lsb_first into registers.
  - Sets cnt=0 and enters SHIFT.
  - First chunk appears on out_data the cycle after accept; latency is 1 cycle.
- Beat occurs when out_valid & out_ready.
  - If not last: cnt increments.
  - If last and a simultaneous accept occurs: new word loaded, cnt=0, stay in SHIFT. This is back-to-back operation with no bubble.
  - If last and no accept: return to IDLE, out_valid=0 next cycle.
- Stall: while out_valid & ~out_ready, out_data, out_last and cnt hold. in_ready=0. in_data is ignored.
- Chunk selection, natural order (in_lsb_first=0): out_data = word[cnt*chunk_width +: chunk_width]. Chunk 0 carries word bits 0..chunk_width-1.
- Chunk selection, reversed order (in_lsb_first=1): out_data[j] = word[width-1-(cnt*chunk_width+j)].
- out_last = out_valid & (cnt == num_chunks-1).
- num_chunks==1: single-register pass-through. out_last==out_valid. Full rate is sustained via in_ready on the last beat.
- out_data is driven only from registers; no combinational path from in_data to out_data.
- out_data is 0 whenever out_valid=0.
- Reset mid-word discards the word. No partial beats follow.
- in_valid while in_ready=0 has no effect. Upstream holds the word.

Optional Feature:
- Macro: C_CHUNK_SERIALIZER_PARITY_EN.
- Defined: adds output port out_parity (1 bit).
  - out_parity = XOR of all width bits of the held word, computed at accept and registered.
  - Stable for every beat of the word; 0 when out_valid=0; reset value 0.
  - Unaffected by in_lsb_first.
- Undefined: port and parity logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_last=0, busy=0, in_ready=1; no word accepted.
- Natural order: width=32, chunk_width=8, in_data=32'h11223344, in_lsb_first=0, out_ready=1 -> out_data 8'h11,8'h22,8'h33,8'h44 on cycles 1-4. out_last only on cycle 4. Parity build: out_parity=0.
- Reversed order: same word, in_lsb_first=1 -> out_data 8'h22,8'hCC,8'h44,8'h88. out_last on the 4th beat.
- Back-to-back: in_valid held with 32'hA5A5A5A5 then 32'h0F0F0F0F, out_ready=1 -> 8 consecutive valid beats with no bubble. in_ready=1 only on the last-beat cycles (4 and 8).
- Stall: deassert out_ready for 3 cycles while out_data=8'h22 -> out_data, out_last and cnt hold, in_ready=0. Sequence resumes with 8'h33.
- Reset mid-word: reset asserted during beat 2 -> next cycle out_valid=0, in_ready=1. A new word then starts at chunk 0.
